// File: rtl/doorlock_ctrl_if.sv
// Keypad, nibble-buffer and actuator signals of the door lock controller.
// master: keypad/buffer side; slave: doorlock_ctrl.
interface doorlock_ctrl_if;
  logic         key_valid;
  logic [3:0]   key_code;
  logic [127:0] buff_data;
  logic         buff_limit;
  logic         buff_sl;
  logic [3:0]   buff_din;
  logic         buff_rst;
  logic         unlock;
  logic         err;
  logic         alarm;
  logic [2:0]   state;

  modport master (
    output key_valid, key_code, buff_data, buff_limit,
    input  buff_sl, buff_din, buff_rst, unlock, err, alarm, state
  );

  modport slave (
    input  key_valid, key_code, buff_data, buff_limit,
    output buff_sl, buff_din, buff_rst, unlock, err, alarm, state
  );
endinterface

// File: rtl/doorlock_ctrl.sv
// Door lock sequencer: turns keypad events into buffer shift/clear strobes,
// checks the entered PIN, drives timed unlock/err/alarm and handles PIN reprogramming.
module doorlock_ctrl #(
  parameter int unsigned  OPEN_CYCLES = 1000,
  parameter int unsigned  ERR_CYCLES  = 200,
  parameter int unsigned  LOCK_CYCLES = 5000,
  parameter int unsigned  MAX_FAILS   = 3,
  parameter logic [127:0] DEFAULT_PW  = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_1234
) (
  input logic            clk,
  input logic            rstn,
  doorlock_ctrl_if.slave bus
);

  localparam int unsigned MaxAB  = (OPEN_CYCLES > ERR_CYCLES) ? OPEN_CYCLES : ERR_CYCLES;
  localparam int unsigned MaxCyc = (MaxAB > LOCK_CYCLES) ? MaxAB : LOCK_CYCLES;
  localparam int unsigned TimerW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [TimerW-1:0] OpenLoad = TimerW'(OPEN_CYCLES - 1);
  localparam logic [TimerW-1:0] ErrLoad  = TimerW'(ERR_CYCLES - 1);
  localparam logic [TimerW-1:0] LockLoad = TimerW'(LOCK_CYCLES - 1);
  localparam logic [TimerW-1:0] TimerOne = TimerW'(1);
  localparam logic [3:0]        MaxFails = 4'(MAX_FAILS);

  typedef enum logic [2:0] {
    StLocked  = 3'd0,
    StCheck   = 3'd1,
    StOpen    = 3'd2,
    StError   = 3'd3,
    StLockout = 3'd4,
    StProg    = 3'd5
  } state_e;

  state_e            state_q;
  logic [127:0]      pw_q;
  logic [3:0]        fail_cnt_q;
  logic [TimerW-1:0] timer_q;
  logic              buff_sl_q;
  logic [3:0]        buff_din_q;
  logic              buff_rst_q;
  logic              unlock_q;
  logic              err_q;
  logic              alarm_q;

  logic       key_digit;
  logic       key_enter;
  logic       key_clear;
  logic       key_prog;
  logic       buf_empty;
  logic       pw_match;
  logic       timer_zero;
  logic [3:0] fail_next;

  // Key decode and PIN comparison.
  always_comb begin
    key_digit  = bus.key_valid && (bus.key_code <= 4'd9);
    key_enter  = bus.key_valid && (bus.key_code == 4'hA);
    key_clear  = bus.key_valid && (bus.key_code == 4'hB);
    key_prog   = bus.key_valid && (bus.key_code == 4'hC);
    buf_empty  = (bus.buff_data == '1);
    // An all-F buffer holds no digits and must never count as a match.
    pw_match   = (bus.buff_data == pw_q) && !buf_empty;
    timer_zero = (timer_q == '0);
    fail_next  = fail_cnt_q + 4'd1;
  end

  // Main FSM with registered strobes and indicators.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StLocked;
      pw_q       <= DEFAULT_PW;
      fail_cnt_q <= '0;
      timer_q    <= '0;
      buff_sl_q  <= 1'b0;
      buff_din_q <= '0;
      buff_rst_q <= 1'b0;
      unlock_q   <= 1'b0;
      err_q      <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      buff_sl_q  <= 1'b0;
      buff_din_q <= '0;
      buff_rst_q <= 1'b0;
      unique case (state_q)
        StLocked: begin
          if (key_digit && bus.buff_limit) begin
            buff_sl_q  <= 1'b1;
            buff_din_q <= bus.key_code;
          end else if (key_clear) begin
            buff_rst_q <= 1'b1;
          end else if (key_enter) begin
            state_q <= StCheck;
          end
        end
        StCheck: begin
          buff_rst_q <= 1'b1;
          if (pw_match) begin
            state_q    <= StOpen;
            unlock_q   <= 1'b1;
            fail_cnt_q <= '0;
            timer_q    <= OpenLoad;
          end else begin
            fail_cnt_q <= fail_next;
            if (fail_next == MaxFails) begin
              state_q <= StLockout;
              alarm_q <= 1'b1;
              timer_q <= LockLoad;
            end else begin
              state_q <= StError;
              err_q   <= 1'b1;
              timer_q <= ErrLoad;
            end
          end
        end
        StOpen: begin
          if (key_prog) begin
            state_q    <= StProg;
            unlock_q   <= 1'b0;
            timer_q    <= OpenLoad;
            buff_rst_q <= 1'b1;
          end else if (timer_zero) begin
            state_q  <= StLocked;
            unlock_q <= 1'b0;
          end else begin
            timer_q <= timer_q - TimerOne;
          end
        end
        StError: begin
          if (timer_zero) begin
            state_q <= StLocked;
            err_q   <= 1'b0;
          end else begin
            timer_q <= timer_q - TimerOne;
          end
        end
        StLockout: begin
          if (timer_zero) begin
            state_q    <= StLocked;
            alarm_q    <= 1'b0;
            fail_cnt_q <= '0;
          end else begin
            timer_q <= timer_q - TimerOne;
          end
        end
        StProg: begin
          // Any key activity restarts the inactivity timeout.
          if (bus.key_valid) begin
            timer_q <= OpenLoad;
            if (key_digit && bus.buff_limit) begin
              buff_sl_q  <= 1'b1;
              buff_din_q <= bus.key_code;
            end else if (key_clear) begin
              buff_rst_q <= 1'b1;
            end else if (key_enter) begin
              state_q <= StLocked;
              if (!buf_empty) begin
                pw_q       <= bus.buff_data;
                buff_rst_q <= 1'b1;
              end
            end
          end else if (timer_zero) begin
            state_q    <= StLocked;
            buff_rst_q <= 1'b1;
          end else begin
            timer_q <= timer_q - TimerOne;
          end
        end
        default: state_q <= StLocked;
      endcase
    end
  end

  assign bus.buff_sl  = buff_sl_q;
  assign bus.buff_din = buff_din_q;
  assign bus.buff_rst = buff_rst_q;
  assign bus.unlock   = unlock_q;
  assign bus.err      = err_q;
  assign bus.alarm    = alarm_q;
  assign bus.state    = state_q;

endmodule

// File: doc/doorlock_ctrl.md
# doorlock_ctrl

Sequencing controller for the keypad input buffer of the door lock. It turns single-cycle keypad events into shift (`buff_sl`) and clear (`buff_rst`) strobes for the 128-bit nibble buffer. On Enter it compares the buffer against a stored PIN and drives unlock, error and alarm outputs through a timed state machine. It also handles PIN reprogramming and lockout after repeated failures, and sits between the keypad scanner and the buffer/actuator logic.

## Interface
Parameters:
- `OPEN_CYCLES`, default 1000: cycles `unlock` stays high; also the PROG inactivity timeout.
- `ERR_CYCLES`, default 200: cycles `err` stays high after a wrong PIN.
- `LOCK_CYCLES`, default 5000: cycles `alarm` stays high in lockout.
- `MAX_FAILS`, default 3: consecutive wrong PINs (1..15) that trigger lockout.
- `DEFAULT_PW`, default 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_1234: PIN after reset, F-padded in buffer format.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rstn`  in  1  synchronous active-low reset.
- `key_valid`  in  1  one-cycle strobe, `key_code` valid.
- `key_code`  in  4  0-9 digit, A Enter, B Clear, C Program; D/E/F ignored.
- `buff_data`  in  128  current buffer contents.
- `buff_limit`  in  1  high while buffer MSB nibble is F, i.e. space for another digit.
- `buff_sl`  out  1  registered one-cycle shift strobe.
- `buff_din`  out  4  digit to shift; valid with `buff_sl`, 0 otherwise.
- `buff_rst`  out  1  registered one-cycle buffer clear strobe.
- `unlock`  out  1  door release.
- `err`  out  1  wrong-PIN indicator.
- `alarm`  out  1  lockout indicator.
- `state`  out  3  LOCKED=0, CHECK=1, OPEN=2, ERROR=3, LOCKOUT=4, PROG=5.

## Operation
- Reset (`rstn`=0 at an edge): state LOCKED, `pw_reg`=DEFAULT_PW, `fail_cnt`=0, timer=0, all outputs 0.
- Digit key (0-9) in LOCKED or PROG:
  - with `buff_limit`=1: next cycle `buff_sl`=1, `buff_din`=digit.
  - with `buff_limit`=0: ignored; buffer holds 32 digits maximum.
- Clear (B) in LOCKED or PROG: next cycle `buff_rst`=1; state unchanged.
- LOCKED, Enter (A): go to CHECK.
- CHECK (exactly 1 cycle):
  - Match is `buff_data == pw_reg` over all 128 bits; an empty buffer (all F) never matches.
  - Match: go to OPEN, `fail_cnt`=0, `buff_rst` pulse.
  - Mismatch: `fail_cnt`+1 and `buff_rst` pulse; go to LOCKOUT if the new count equals MAX_FAILS, else ERROR.
- OPEN:
  - `unlock`=1 for exactly OPEN_CYCLES, then go to LOCKED.
  - Key C: go to PROG immediately (`unlock` drops), timer reloads with OPEN_CYCLES, `buff_rst` pulse.
  - All other keys ignored.
- PROG:
  - Digits and Clear behave as in LOCKED; each key reloads the timer.
  - Enter with non-empty buffer: `pw_reg`<=`buff_data`, `buff_rst` pulse, go to LOCKED.
  - Enter with empty buffer: go to LOCKED, `pw_reg` unchanged.
  - Timer expiry: `buff_rst` pulse, go to LOCKED, `pw_reg` unchanged.
- ERROR: `err`=1 for ERR_CYCLES, keys ignored, then go to LOCKED.
- LOCKOUT: `alarm`=1 for LOCK_CYCLES, keys ignored, then go to LOCKED with `fail_cnt`=0.
- Keys arriving in CHECK are dropped.
- The timer is a down-counter sized by $clog2 of the largest cycle parameter; it is loaded with N-1 on state entry, and exit occurs on the cycle it reads 0.

## Timing
- Key sampled at edge k produces `buff_sl`/`buff_rst` high during cycle k..k+1; the buffer updates at edge k+1.
- Enter immediately after a digit (back-to-back `key_valid`) is legal. CHECK runs in the cycle after Enter is sampled, when the last digit is already in `buff_data`.
- Enter sampled at edge k gives CHECK in cycle k. OPEN/ERROR/LOCKOUT outputs go high from edge k+1, and the `buff_rst` pulse is in the same cycle.
- `unlock`, `err` and `alarm` are registered, mutually exclusive and glitch-free. Each is high for exactly its parameter cycle count.
- `buff_sl` and `buff_rst` are never high in the same cycle.
- Reset mid-operation:
  - returns to LOCKED at that edge and clears all outputs;
  - `pw_reg` reverts to DEFAULT_PW;
  - no `buff_rst` pulse is issued, because the buffer is reset by the same `rstn`.

## Test plan
- Reset, keys 1,2,3,4,A: four `buff_sl` pulses with `buff_din`=1,2,3,4; CHECK 1 cycle; `unlock` high exactly OPEN_CYCLES; one `buff_rst`; `fail_cnt`=0.
- Keys 9,A three times (MAX_FAILS=3): `err` pulses twice for ERR_CYCLES each; the third failure gives `alarm` for LOCK_CYCLES; keys during LOCKOUT produce no strobes; then LOCKED.
- Wrong, wrong, then correct PIN: the correct entry opens and clears `fail_cnt`; a further two wrong entries give `err`, not `alarm`.
- In OPEN press C, keys 7,7,A: `pw_reg`=…FF77; 1,2,3,4,A now gives `err`; 7,7,A gives `unlock`.
- 33 digit keys: exactly 32 `buff_sl` pulses, the 33rd is ignored (`buff_limit`=0); then B gives one `buff_rst`; A with empty buffer gives `err`.
- Assert `rstn`=0 mid-OPEN and mid-PROG: `unlock`=0 and state=0 at that edge; `pw_reg` back to DEFAULT_PW, so 1,2,3,4,A unlocks.
